// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Registered program-counter unit for the 64-bit pipeline. Holds the fetch
//   PC, advances it by 4 when fetch accepts it, and redirects it when a
//   branch resolves taken. Immediate offsets (imm19 / imm26, in words) are
//   sign-extended and scaled internally. They are added to the PC of the
//   resolving branch, not to the current fetch PC.
//
// Handshake toward fetch (valid/ready):
//   pc is offered whenever pc_valid=1. It is consumed on an edge where
//   pc_valid & fetch_ready. While pc_valid=1 and fetch_ready=0, pc stays
//   stable. Only a redirect or reset may change it. A redirect discards any
//   unaccepted PC.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   fetch_ready          fetch accepts pc this cycle
//   pc, pc_plus4         current fetch PC and pc+4 (combinational, wraps)
//   pc_valid             pc is presentable to fetch (1 from first edge out of reset)
//   br_valid, br_taken   branch resolves this cycle / is taken
//   br_mode              00 cond imm, 01 uncond imm, 10 register, 11 reserved
//   br_pc                PC of the resolving branch
//   cond_addr, br_addr   raw signed word offsets (imm19 / imm26)
//   br_reg               register target for mode 10
//   flush                1-cycle registered pulse after each redirect
//   misalign_err         sticky: misaligned redirect target or reserved mode
//   redirect_cnt         saturating count of applied redirects
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter int              COND_W       = 19,
    parameter int              UNCOND_W     = 26,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_ready,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                pc_valid,
    input  logic                br_valid,
    input  logic                br_taken,
    input  logic [1:0]          br_mode,
    input  logic [XLEN-1:0]     br_pc,
    input  logic [COND_W-1:0]   cond_addr,
    input  logic [UNCOND_W-1:0] br_addr,
    input  logic [XLEN-1:0]     br_reg,
    output logic                flush,
    output logic                misalign_err,
    output logic [CNT_W-1:0]    redirect_cnt
);

    localparam logic [1:0]       MODE_COND   = 2'b00;
    localparam logic [1:0]       MODE_UNCOND = 2'b01;
    localparam logic [1:0]       MODE_REG    = 2'b10;
    localparam logic [1:0]       MODE_RSVD   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [XLEN-1:0] cond_off;
    logic [XLEN-1:0] uncond_off;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            reserved_hit;
    logic            target_misaligned;

    assign pc_plus4 = pc + XLEN'(4);

    // Sign-extend the word offsets to XLEN, then scale them to bytes.
    // Bits shifted out of the top are dropped, so the sum is mod 2^XLEN.
    assign cond_off   = {{(XLEN-COND_W){cond_addr[COND_W-1]}}, cond_addr} << 2;
    assign uncond_off = {{(XLEN-UNCOND_W){br_addr[UNCOND_W-1]}}, br_addr} << 2;

    always_comb begin
        target = br_reg;
        case (br_mode)
            MODE_COND:   target = br_pc + cond_off;
            MODE_UNCOND: target = br_pc + uncond_off;
            MODE_REG:    target = br_reg;
            default:     target = br_reg;
        endcase
    end

    assign redirect          = br_valid & br_taken & (br_mode != MODE_RSVD);
    assign reserved_hit      = br_valid & br_taken & (br_mode == MODE_RSVD);
    assign target_misaligned = (target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            pc_valid <= 1'b1;
            flush    <= redirect;
            // A redirect wins over the +4 advance, even when fetch_ready is high.
            if (redirect) begin
                pc <= {target[XLEN-1:2], 2'b00};
                if (redirect_cnt != CNT_MAX) begin
                    redirect_cnt <= redirect_cnt + CNT_W'(1);
                end
            end else if (pc_valid && fetch_ready) begin
                pc <= pc_plus4;
            end
            if ((redirect && target_misaligned) || reserved_hit) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule
